param_down_counter: RTL



---
 rtl/param_down_counter_if.sv | 24 ++
 rtl/param_down_counter.sv | 99 +++++++++
 2 files changed

// File: rtl/param_down_counter_if.sv
// Control and status bundle for the loadable segmented down-counter.
// The master side drives load/start/stop; the counter drives the status back.
interface param_down_counter_if #(
  parameter int WIDTH = 32
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;

  modport master (
    output load, load_value, start, stop, auto_reload,
    input  q, busy, tc
  );

  modport slave (
    input  load, load_value, start, stop, auto_reload,
    output q, busy, tc
  );
endinterface

// File: rtl/param_down_counter.sv
// Loadable down-counter/timer built from SEG_W-wide segments with borrow chaining.
// It pulses tc for one cycle at terminal count and can auto-reload for periodic ticks.
module param_down_counter #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input logic                clk,
  input logic                rst,
  param_down_counter_if.slave bus
);

  localparam int NSEG = WIDTH / SEG_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             busy_q;
  logic             tc_q;

  logic [WIDTH-1:0] count_d;
  logic [NSEG-1:0]  lowerZero;

  // A segment borrows only when every segment below it is zero, so the whole
  // chain resolves in one cycle and q matches a plain binary decrement.
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG_W-1:0] seg;
    assign seg = count_q[k*SEG_W +: SEG_W];
    if (k == 0) begin : g_first
      assign lowerZero[k] = 1'b1;
    end else begin : g_rest
      assign lowerZero[k] = lowerZero[k-1] & (count_q[(k-1)*SEG_W +: SEG_W] == '0);
    end
    assign count_d[k*SEG_W +: SEG_W] = lowerZero[k] ? (seg - SEG_W'(1)) : seg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.load) begin
        count_q  <= bus.load_value;
        reload_q <= bus.load_value;
        state_q  <= IDLE;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start && !bus.stop && (count_q != '0)) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            // Stop freezes q on this edge, even when it would have hit terminal count.
            if (bus.stop) begin
              state_q <= HOLD;
            end else if (count_q != WIDTH'(1)) begin
              count_q <= count_d;
            end else begin
              tc_q <= 1'b1;
              if (bus.auto_reload) begin
                count_q <= reload_q;
              end else begin
                count_q <= '0;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (bus.start && !bus.stop) begin
              state_q <= RUN;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.q    = count_q;
  assign bus.busy = busy_q;
  assign bus.tc   = tc_q;

endmodule
